// File: rtl/multi_pulse_seq_pkg.sv
// Shared types and default widths for the multi-channel pulse sequencer.
package pulse_seq_pkg;

    localparam int unsigned TW         = 16;
    localparam int unsigned CW_DEF     = 32;
    localparam int unsigned SYNC_W_DEF = 8;
    localparam int unsigned GUARD      = 16;
    localparam int unsigned RW         = 8;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        HIGH,
        GAP,
        DONE
    } chan_state_t;

    typedef struct packed {
        logic [TW-1:0] del;
        logic [TW-1:0] wid;
        logic [TW-1:0] spc;
        logic [RW-1:0] nrep;
    } chan_cfg_t;

    // Repeats remaining after the first pulse; a count of 0 behaves like 1.
    function automatic logic [RW-1:0] last_rep(input logic [RW-1:0] nrep);
        return (nrep == '0) ? '0 : nrep - RW'(1);
    endfunction

endpackage

// File: rtl/multi_pulse_seq_if.sv
// Control/status bundle between the serial control block and the pulse sequencer.
interface multi_pulse_seq_if
    import pulse_seq_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = CW_DEF
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           run;
    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [TW-1:0]  cfg_del;
    logic [TW-1:0]  cfg_wid;
    logic [TW-1:0]  cfg_spc;
    logic [RW-1:0]  cfg_nrep;
    logic [CW-1:0]  cfg_per;
    logic           cfg_commit;
    logic           commit_pend;
    logic           sync_on;
    logic [NCH-1:0] pulse_on;
    logic           pulse_any;
    logic           inhib;

    modport master (
        output run, cfg_wr, cfg_ch, cfg_del, cfg_wid, cfg_spc, cfg_nrep, cfg_per, cfg_commit,
        input  commit_pend, sync_on, pulse_on, pulse_any, inhib
    );

    modport slave (
        input  run, cfg_wr, cfg_ch, cfg_del, cfg_wid, cfg_spc, cfg_nrep, cfg_per, cfg_commit,
        output commit_pend, sync_on, pulse_on, pulse_any, inhib
    );

endinterface

// File: rtl/multi_pulse_seq_chan.sv
// One pulse channel: delay, then nrep pulses of width wid separated by spc-cycle gaps.
module pulse_chan
    import pulse_seq_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      halt_i,
    input  logic      start_i,
    input  chan_cfg_t cfg_i,
    output logic      pulse_o,
    output logic      pulse_nxt_c
);

    chan_state_t   state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          pulse_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rep_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            pulse_q <= pulse_nxt_c;
        end
    end

    // cnt holds the cycles left in the current state after this one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        if (halt_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            rep_d   = '0;
        end else if (start_i) begin
            rep_d = last_rep(cfg_i.nrep);
            if (cfg_i.wid == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cfg_i.del == '0) begin
                state_d = HIGH;
                cnt_d   = cfg_i.wid - TW'(1);
            end else begin
                state_d = DELAY;
                cnt_d   = cfg_i.del - TW'(1);
            end
        end else begin
            unique case (state_q)
                DELAY, GAP: begin
                    if (cnt_q == '0) begin
                        state_d = HIGH;
                        cnt_d   = cfg_i.wid - TW'(1);
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                HIGH: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TW'(1);
                    end else if (rep_q == '0) begin
                        state_d = DONE;
                    end else begin
                        rep_d = rep_q - RW'(1);
                        // A zero gap re-enters HIGH directly so the pulses merge.
                        if (cfg_i.spc == '0) begin
                            cnt_d = cfg_i.wid - TW'(1);
                        end else begin
                            state_d = GAP;
                            cnt_d   = cfg_i.spc - TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        pulse_nxt_c = (state_d == HIGH);
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/multi_pulse_seq.sv
// NCH-channel pulse sequencer with shadow config committed at period wraps.
// Define PULSE_INHIBIT_EN to build the receiver inhibit/guard logic; otherwise inhib is 0.
module multi_pulse_seq
    import pulse_seq_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CW     = CW_DEF,
    parameter int unsigned SYNC_W = SYNC_W_DEF
) (
    input  logic             clk_pll,
    input  logic             reset,
    multi_pulse_seq_if.slave bus
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           running_q;
    logic [CW-1:0]  pc_q, pc_d;
    logic [CW-1:0]  per_shd_q, per_act_q, per_act_d;
    chan_cfg_t      shd_q [NCH];
    chan_cfg_t      act_q [NCH];
    chan_cfg_t      act_d [NCH];
    logic           pend_q, pend_d;
    logic           sync_q, sync_d;
    logic           any_q, any_d;
    logic [NCH-1:0] pulse_w, pulse_d;
    logic           inhib_w;
    logic [CW-1:0]  len_cur_c, len_nxt_c, slim_nxt_c;
    logic           wrap_c, start_c, commit_c, halt_c;

    function automatic logic [CW-1:0] per_len(input logic [CW-1:0] per);
        return (per < CW'(2)) ? CW'(2) : per;
    endfunction

    // Period counter, commit and sync decisions; sync is judged against the next pc.
    always_comb begin
        halt_c    = !bus.run;
        len_cur_c = per_len(per_act_q);
        wrap_c    = running_q && (pc_q == len_cur_c - CW'(1));
        start_c   = bus.run && (!running_q || wrap_c);
        commit_c  = bus.run && wrap_c && pend_q;
        per_act_d = commit_c ? per_shd_q : per_act_q;
        for (int i = 0; i < NCH; i++) begin
            act_d[i] = commit_c ? shd_q[i] : act_q[i];
        end
        pend_d     = bus.cfg_commit ? 1'b1 : (commit_c ? 1'b0 : pend_q);
        pc_d       = (halt_c || start_c) ? '0 : pc_q + CW'(1);
        len_nxt_c  = per_len(per_act_d);
        slim_nxt_c = (CW'(SYNC_W) < len_nxt_c - CW'(1)) ? CW'(SYNC_W) : len_nxt_c - CW'(1);
        sync_d     = bus.run && (pc_d < slim_nxt_c);
        any_d      = |pulse_d;
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            running_q <= 1'b0;
            pc_q      <= '0;
            per_shd_q <= '0;
            per_act_q <= '0;
            pend_q    <= 1'b0;
            sync_q    <= 1'b0;
            any_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shd_q[i] <= '0;
                act_q[i] <= '0;
            end
        end else begin
            running_q <= bus.run;
            pc_q      <= pc_d;
            per_act_q <= per_act_d;
            pend_q    <= pend_d;
            sync_q    <= sync_d;
            any_q     <= any_d;
            if (bus.cfg_wr) begin
                per_shd_q <= bus.cfg_per;
            end
            for (int i = 0; i < NCH; i++) begin
                if (bus.cfg_wr && (bus.cfg_ch == CHW'(i))) begin
                    shd_q[i] <= '{del: bus.cfg_del, wid: bus.cfg_wid,
                                  spc: bus.cfg_spc, nrep: bus.cfg_nrep};
                end
                act_q[i] <= act_d[i];
            end
        end
    end

    // Channels see the next active config so a committed change takes effect at the restart.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pulse_chan u_chan (
            .clk_i       (clk_pll),
            .rst_i       (reset),
            .halt_i      (halt_c),
            .start_i     (start_c),
            .cfg_i       (act_d[g]),
            .pulse_o     (pulse_w[g]),
            .pulse_nxt_c (pulse_d[g])
        );
    end

`ifdef PULSE_INHIBIT_EN
    localparam int unsigned GW = $clog2(GUARD + 1);

    logic [GW-1:0] guard_q, guard_d;
    logic          inhib_q, inhib_d;

    // Any pulse (re)loads the guard; inhib stays up until it runs out.
    always_comb begin
        guard_d = guard_q;
        inhib_d = 1'b0;
        if (halt_c) begin
            guard_d = '0;
        end else if (any_d) begin
            guard_d = GW'(GUARD);
            inhib_d = 1'b1;
        end else if (guard_q != '0) begin
            guard_d = guard_q - GW'(1);
            inhib_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            guard_q <= '0;
            inhib_q <= 1'b0;
        end else begin
            guard_q <= guard_d;
            inhib_q <= inhib_d;
        end
    end

    assign inhib_w = inhib_q;
`else
    assign inhib_w = 1'b0;
`endif

    assign bus.commit_pend = pend_q;
    assign bus.sync_on     = sync_q;
    assign bus.pulse_on    = pulse_w;
    assign bus.pulse_any   = any_q;
    assign bus.inhib       = inhib_w;

endmodule

// File: tb/tb_multi_pulse_seq.sv
// Directed bench for multi_pulse_seq: pulse trains, overrun, commit timing, run/reset and inhibit.
module tb_multi_pulse_seq;
    import pulse_seq_pkg::*;

    localparam int unsigned NCH = 4;

    logic clk_pll = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    multi_pulse_seq_if #(.NCH(NCH), .CW(CW_DEF)) bus ();

    multi_pulse_seq #(.NCH(NCH), .CW(CW_DEF), .SYNC_W(SYNC_W_DEF)) dut (
        .clk_pll (clk_pll),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_pll = ~clk_pll;

    task automatic step();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic do_reset();
        bus.run        = 1'b0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_del    = '0;
        bus.cfg_wid    = '0;
        bus.cfg_spc    = '0;
        bus.cfg_nrep   = '0;
        bus.cfg_per    = '0;
        bus.cfg_commit = 1'b0;
        reset          = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic write_ch(input int ch, input int del, input int wid, input int spc,
                            input int nrep, input int per);
        bus.cfg_ch   = 2'(ch);
        bus.cfg_del  = 16'(del);
        bus.cfg_wid  = 16'(wid);
        bus.cfg_spc  = 16'(spc);
        bus.cfg_nrep = 8'(nrep);
        bus.cfg_per  = 32'(per);
        bus.cfg_wr   = 1'b1;
        step();
        bus.cfg_wr = 1'b0;
    endtask

    // From reset the active period is 2: first run cycle pc0, pc1 wraps and commits, then new pc0.
    task automatic go();
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        bus.run        = 1'b1;
        step();
        step();
        step();
    endtask

    // Checks ncyc cycles starting at pc0: channel ch high in up to three pc ranges, others low.
    task automatic chk(input string nm, input int ncyc, input int per, input int ch,
                       input int lo0, input int hi0, input int lo1, input int hi1,
                       input int lo2, input int hi2, input int slim, input logic pend_exp);
        for (int k = 0; k < ncyc; k++) begin
            int             pc;
            logic           hit;
            logic [NCH-1:0] ev;
            pc  = k % per;
            hit = (pc >= lo0 && pc <= hi0) || (pc >= lo1 && pc <= hi1) || (pc >= lo2 && pc <= hi2);
            ev  = hit ? (NCH'(1) << ch) : '0;
            total++;
            if (bus.pulse_on !== ev) begin
                bad++;
                $display("FAIL %s pulse_on pc=%0d got=%b want=%b", nm, pc, bus.pulse_on, ev);
            end
            total++;
            if (bus.pulse_any !== hit) begin
                bad++;
                $display("FAIL %s pulse_any pc=%0d got=%b want=%b", nm, pc, bus.pulse_any, hit);
            end
            total++;
            if (bus.sync_on !== (pc < slim)) begin
                bad++;
                $display("FAIL %s sync_on pc=%0d got=%b want=%b", nm, pc, bus.sync_on, (pc < slim));
            end
            total++;
            if (bus.commit_pend !== pend_exp) begin
                bad++;
                $display("FAIL %s commit_pend pc=%0d got=%b want=%b", nm, pc, bus.commit_pend, pend_exp);
            end
`ifndef PULSE_INHIBIT_EN
            total++;
            if (bus.inhib !== 1'b0) begin
                bad++;
                $display("FAIL %s inhib pc=%0d got=%b want=0", nm, pc, bus.inhib);
            end
`endif
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.run = 1'b0;
        step();
        total++;
        if (bus.pulse_on !== 4'b0000) begin bad++; $display("FAIL reset pulse_on got=%b want=0000", bus.pulse_on); end
        total++;
        if (bus.sync_on !== 1'b0) begin bad++; $display("FAIL reset sync_on got=%b want=0", bus.sync_on); end
        total++;
        if (bus.pulse_any !== 1'b0) begin bad++; $display("FAIL reset pulse_any got=%b want=0", bus.pulse_any); end
        total++;
        if (bus.commit_pend !== 1'b0) begin bad++; $display("FAIL reset commit_pend got=%b want=0", bus.commit_pend); end
        total++;
        if (bus.inhib !== 1'b0) begin bad++; $display("FAIL reset inhib got=%b want=0", bus.inhib); end
    endtask

    task automatic test_single();
        do_reset();
        write_ch(0, 10, 5, 0, 1, 100);
        go();
        chk("single", 200, 100, 0, 10, 14, -1, -1, -1, -1, 8, 1'b0);
    endtask

    task automatic test_train();
        do_reset();
        write_ch(1, 0, 3, 4, 3, 100);
        go();
        chk("train", 100, 100, 1, 0, 2, 7, 9, 14, 16, 8, 1'b0);
    endtask

    task automatic test_overrun();
        do_reset();
        write_ch(0, 15, 10, 0, 1, 20);
        go();
        chk("overrun", 40, 20, 0, 15, 19, -1, -1, -1, -1, 8, 1'b0);
    endtask

    // Short period clips sync to P-1; wid=0 disables ch2; nrep=0 gives one pulse on ch3.
    task automatic test_short_period();
        do_reset();
        write_ch(2, 0, 0, 0, 4, 5);
        write_ch(3, 1, 2, 1, 0, 5);
        go();
        chk("short", 10, 5, 3, 1, 2, -1, -1, -1, -1, 4, 1'b0);
    endtask

    task automatic test_commit();
        do_reset();
        write_ch(0, 10, 5, 0, 1, 100);
        go();
        repeat (50) step();
        write_ch(0, 30, 5, 0, 1, 100);
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        total++;
        if (bus.commit_pend !== 1'b1) begin bad++; $display("FAIL commit_mid pend pc=52 got=%b want=1", bus.commit_pend); end
        repeat (47) step();
        total++;
        if (bus.commit_pend !== 1'b1) begin bad++; $display("FAIL commit_mid pend pc=99 got=%b want=1", bus.commit_pend); end
        step();
        chk("commit_new", 100, 100, 0, 30, 34, -1, -1, -1, -1, 8, 1'b0);
        // Commit on the wrap cycle lands one period later.
        write_ch(0, 50, 5, 0, 1, 100);
        repeat (98) step();
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        chk("commit_wrap_old", 100, 100, 0, 30, 34, -1, -1, -1, -1, 8, 1'b1);
        chk("commit_wrap_new", 100, 100, 0, 50, 54, -1, -1, -1, -1, 8, 1'b0);
    endtask

    task automatic test_run_toggle();
        do_reset();
        write_ch(0, 10, 5, 0, 1, 100);
        go();
        repeat (12) step();
        total++;
        if (bus.pulse_on !== 4'b0001) begin bad++; $display("FAIL run_pre pulse_on got=%b want=0001", bus.pulse_on); end
        bus.run        = 1'b0;
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.pulse_on !== 4'b0000 || bus.pulse_any !== 1'b0 || bus.sync_on !== 1'b0 || bus.inhib !== 1'b0) begin
                bad++;
                $display("FAIL run_low outputs cyc=%0d got=%b/%b/%b/%b want=0000/0/0/0", k,
                         bus.pulse_on, bus.pulse_any, bus.sync_on, bus.inhib);
            end
            total++;
            if (bus.commit_pend !== 1'b1) begin bad++; $display("FAIL run_low pend cyc=%0d got=%b want=1", k, bus.commit_pend); end
            step();
        end
        bus.run = 1'b1;
        step();
        chk("run_restart", 100, 100, 0, 10, 14, -1, -1, -1, -1, 8, 1'b1);
        total++;
        if (bus.commit_pend !== 1'b0 || bus.sync_on !== 1'b1) begin
            bad++;
            $display("FAIL run_wrap pend/sync got=%b/%b want=0/1", bus.commit_pend, bus.sync_on);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_ch(0, 10, 5, 0, 1, 100);
        go();
        repeat (12) step();
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        total++;
        if (bus.pulse_on !== 4'b0001 || bus.commit_pend !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre pulse/pend got=%b/%b want=0001/1", bus.pulse_on, bus.commit_pend);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.pulse_on !== 4'b0000 || bus.pulse_any !== 1'b0) begin
            bad++;
            $display("FAIL rstmid pulse/any got=%b/%b want=0000/0", bus.pulse_on, bus.pulse_any);
        end
        total++;
        if (bus.commit_pend !== 1'b0) begin bad++; $display("FAIL rstmid pend got=%b want=0", bus.commit_pend); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_inhibit();
        do_reset();
        write_ch(0, 10, 5, 5, 2, 100);
        go();
        for (int k = 0; k < 200; k++) begin
            int   pc;
            logic ep;
            logic ei;
            pc = k % 100;
            ep = (pc >= 10 && pc <= 14) || (pc >= 20 && pc <= 24);
`ifdef PULSE_INHIBIT_EN
            ei = (pc >= 10 && pc <= 40);
`else
            ei = 1'b0;
`endif
            total++;
            if (bus.pulse_any !== ep) begin bad++; $display("FAIL inhib_any pc=%0d got=%b want=%b", pc, bus.pulse_any, ep); end
            total++;
            if (bus.inhib !== ei) begin bad++; $display("FAIL inhib pc=%0d got=%b want=%b", pc, bus.inhib, ei); end
            step();
        end
    endtask

    initial begin
        bus.run        = 1'b0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_del    = '0;
        bus.cfg_wid    = '0;
        bus.cfg_spc    = '0;
        bus.cfg_nrep   = '0;
        bus.cfg_per    = '0;
        bus.cfg_commit = 1'b0;
        test_reset();
        test_single();
        test_train();
        test_overrun();
        test_short_period();
        test_commit();
        test_run_toggle();
        test_reset_mid();
        test_inhibit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
